// File: rtl/fft_seq_ctrl.sv
// ============================================================================
// Module      : fft_seq_ctrl
// Description : Serial-to-parallel operand loader, launch/latency sequencer and
//               parallel-to-serial result drainer for an 8-point FFT stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_seq_ctrl #(
  parameter int N   = 4,
  parameter int LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2**N-1:0]  in_data,
  output logic             in_ready,
  output logic [8*2**N-1:0] s_bus,
  output logic             launch,
  input  logic [8*2**N-1:0] r_bus,
  output logic             out_valid,
  output logic [2**N-1:0]  out_data,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             frame_done
);

  localparam int         W     = 2**N;
  localparam logic [3:0] LAT_C = 4'(LAT);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_FIRE  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [3:0]     lat_q, lat_d;
  logic [8*W-1:0] sreg_q, sreg_d;
  logic [8*W-1:0] obuf_q, obuf_d;

  logic           w_in_hs;
  logic           w_out_hs;
  logic           w_capture;
  logic [2:0]     w_slot;

  assign w_in_hs   = (state_q == S_LOAD) && in_valid;
  assign w_out_hs  = (state_q == S_DRAIN) && out_ready;
  // lat_q equals the number of cycles since FIRE, so capture lands on the edge ending FIRE+LAT
  assign w_capture = (state_q == S_WAIT) && (lat_q == LAT_C);
  assign w_slot    = {cnt_q[0], cnt_q[1], cnt_q[2]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    sreg_d  = sreg_q;
    obuf_d  = obuf_q;
    case (state_q)
      S_LOAD: begin
        if (w_in_hs) begin
          sreg_d[int'(w_slot)*W +: W] = in_data;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = S_FIRE;
          end
        end
      end
      S_FIRE: begin
        lat_d   = 4'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (w_capture) begin
          obuf_d  = r_bus;
          lat_d   = 4'd0;
          state_d = S_DRAIN;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      S_DRAIN: begin
        if (w_out_hs) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_LOAD;
          end
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= 3'd0;
      idx_q   <= 3'd0;
      lat_q   <= 4'd0;
      sreg_q  <= '0;
      obuf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      sreg_q  <= sreg_d;
      obuf_q  <= obuf_d;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign launch     = (state_q == S_FIRE);
  assign busy       = (state_q != S_LOAD);
  assign s_bus      = sreg_q;
  assign out_valid  = (state_q == S_DRAIN);
  assign out_data   = (state_q == S_DRAIN) ? obuf_q[int'(idx_q)*W +: W] : '0;
  assign out_last   = (state_q == S_DRAIN) && (idx_q == 3'd7);
  assign frame_done = w_out_hs && (idx_q == 3'd7);

endmodule

`default_nettype wire

// File: doc/fft_seq_ctrl.md
FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 The module SHALL have parameter N, default 4, where the data word width is W = 2**N bits.
REQ-002 The module SHALL have parameter LAT, default 3, giving the fft_stage2 datapath latency in cycles from launch to valid results; legal range 1..15.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port in_valid, input, 1 bit: a serial input sample is offered.
REQ-006 The module SHALL have port in_data, input, W bits: the serial input sample.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 The module SHALL have port s_bus, output, 8*W bits: parallel operands s0..s7 to the datapath, with slot j at bits [j*W +: W].
REQ-009 The module SHALL have port launch, output, 1 bit: one-cycle start strobe to the datapath.
REQ-010 The module SHALL have port r_bus, input, 8*W bits: datapath results, with slot j at bits [j*W +: W].
REQ-011 The module SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-012 The module SHALL have port out_data, output, W bits: the serial result word.
REQ-013 The module SHALL have port out_ready, input, 1 bit: the downstream block accepts out_data.
REQ-014 The module SHALL have port out_last, output, 1 bit: marks result word 7 of a frame.
REQ-015 The module SHALL have port busy, output, 1 bit: high in every state other than LOAD.
REQ-016 The module SHALL have port frame_done, output, 1 bit: one-cycle pulse on the final output handshake of a frame.

Function
REQ-017 The state machine SHALL have four states: LOAD, FIRE, WAIT and DRAIN; exactly one frame is in flight at a time.
REQ-018 LOAD state SHALL behave as follows:
- in_ready = 1.
- A handshake is in_valid & in_ready.
- The k-th accepted sample (k = 0..7) is written to s_bus slot bitrev3(k), e.g. k=1 -> slot 4 and k=3 -> slot 6.
- The 3-bit input count increments on each handshake.
REQ-019 On the handshake with k = 7, the machine SHALL go to FIRE next cycle and the input count SHALL wrap to 0; in_ready = 0 in all states except LOAD.
REQ-020 FIRE SHALL last exactly one cycle with launch = 1, then go to WAIT; launch = 0 in every other cycle.
REQ-021 s_bus SHALL hold stable from the FIRE cycle until the machine next returns to LOAD; the operand register is not written outside LOAD handshakes.
REQ-022 WAIT SHALL proceed as follows:
- If FIRE is cycle T, a latency counter counts so that r_bus is registered into an 8-word output buffer at the clock edge ending cycle T+LAT.
- The machine enters DRAIN, and out_valid rises, in cycle T+LAT+1.
REQ-023 DRAIN SHALL proceed as follows:
- out_valid = 1 and out_data = buffer[idx], with idx starting at 0.
- idx advances only on out_valid & out_ready.
- out_data and out_valid hold unchanged while out_ready = 0.
REQ-024 out_last SHALL equal 1 exactly when out_valid = 1 and idx = 7.
REQ-025 When the idx = 7 handshake occurs, frame_done SHALL pulse in that cycle, idx SHALL wrap to 0, and the machine SHALL enter LOAD next cycle, with in_ready = 1 that cycle.
REQ-026 in_valid asserted outside LOAD SHALL be ignored, with no write and no count change.
REQ-027 An out_ready asserted outside DRAIN SHALL have no effect.
REQ-028 r_bus SHALL be sampled only at the single capture edge; changes on r_bus at any other time SHALL NOT affect out_data.
REQ-029 Data SHALL pass through unmodified, with no arithmetic on it.

Reset
REQ-030 While rst = 1 at a rising edge, the following SHALL be forced on that edge:
- state = LOAD; input count, idx and latency counter = 0.
- s_bus and the output buffer = 0.
REQ-031 Outputs SHALL be registered or decoded from registered state. In the cycle after a reset edge: in_ready = 1, launch = 0, out_valid = 0, out_last = 0, out_data = 0, busy = 0, frame_done = 0.
REQ-032 Reset asserted in any state (mid-load, FIRE, WAIT or DRAIN) SHALL abort the frame; a partial frame is discarded and the next accepted sample is k = 0.

Verification
REQ-033 Basic frame, LAT=3, out_ready held 1. Send samples 0x0010..0x0017 on consecutive cycles. Required response:
- s_bus slots 0..7 = 0x10, 0x14, 0x12, 0x16, 0x11, 0x15, 0x13, 0x17.
- launch is high 1 cycle after the 8th handshake.
- With r_bus driven to slot j = 0x0A00+j, out_valid rises at launch cycle + 4.
- out_data = 0x0A00..0x0A07, out_last is on 0x0A07, and frame_done pulses with it.
REQ-034 Input gaps: toggle in_valid 1/0 for 8 samples. Required response: exactly 8 samples captured; launch occurs only after the 8th.
REQ-035 Output backpressure: drive out_ready = 0 for 5 cycles at idx = 3. Required response: out_data holds word 3; no word is lost or duplicated; out_last appears only on word 7.
REQ-036 Busy rejection: assert in_valid with 0xFFFF throughout WAIT and DRAIN. Required response: in_ready = 0 and s_bus unchanged; the next frame's sample 0 lands in slot 0.
REQ-037 Reset mid-operation: assert rst for 1 cycle after 5 samples, and separately during DRAIN at idx = 2. Required response: outputs equal the REQ-031 values next cycle, and a fresh 8-sample frame completes correctly.
REQ-038 LAT=1 build: run one frame. Required response: out_valid rises exactly 2 cycles after launch.
